// File: rtl/nco_ctrl_loader.sv
// Command-frame parser and control-word generator for the NCO: shadows frequency,
// phase and sweep settings from 5-byte register frames and drives live tone/sweep words.
module nco_ctrl_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [27:0] fre_chtr,
    output logic [27:0] pha_chtr,
    output logic        sweep_active,
    output logic        sweep_wrap,
    output logic        cmd_err
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_DATA   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [1:0]        byte_cnt_r;
    logic [7:0]        addr_r;
    logic [31:0]       data_r;
    logic [IDLE_W-1:0] idle_cnt_r;

    logic [27:0] start_r, step_r, stop_r, phase_r;
    logic [31:0] dwell_r, dwell_cnt_r;
    logic [27:0] fre_r, pha_r;
    logic        active_r, wrap_r, err_r;

    logic        accept_s, timeout_s;
    logic        wr_start_s, wr_step_s, wr_stop_s, wr_dwell_s, wr_phase_s, wr_ctrl_s;
    logic        unknown_s, apply_s;
    logic [31:0] dwell_lim_s;
    logic        expire_s;
    logic [28:0] sum_s;
    logic        over_s;

    assign cmd_ready = (state_r == ST_ADDR) || (state_r == ST_DATA);
    assign accept_s  = cmd_valid && cmd_ready;

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ADDR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Parser next-state decode, including the inter-byte timeout abort
    always_comb begin
        state_next_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_ADDR: begin
                if (accept_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (byte_cnt_r == 2'd3) begin
                        state_next_s = ST_COMMIT;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else if (idle_cnt_r == IDLE_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_COMMIT: state_next_s = ST_ADDR;
            default:   state_next_s = ST_ADDR;
        endcase
    end

    // Frame capture: address, MSB-first data shift, byte and idle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= 8'h00;
            data_r     <= 32'h0000_0000;
            byte_cnt_r <= 2'd0;
            idle_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_ADDR: begin
                    idle_cnt_r <= '0;
                    if (accept_s) begin
                        addr_r     <= cmd_data;
                        byte_cnt_r <= 2'd0;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        data_r     <= {data_r[23:0], cmd_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        idle_cnt_r <= '0;
                    end else if (timeout_s) begin
                        idle_cnt_r <= '0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                end
                default: idle_cnt_r <= '0;
            endcase
        end
    end

    // Register-write strobes, only meaningful during the commit cycle
    always_comb begin
        wr_start_s = 1'b0;
        wr_step_s  = 1'b0;
        wr_stop_s  = 1'b0;
        wr_dwell_s = 1'b0;
        wr_phase_s = 1'b0;
        wr_ctrl_s  = 1'b0;
        unknown_s  = 1'b0;
        if (state_r == ST_COMMIT) begin
            case (addr_r)
                8'h01:   wr_start_s = 1'b1;
                8'h02:   wr_step_s  = 1'b1;
                8'h03:   wr_stop_s  = 1'b1;
                8'h04:   wr_dwell_s = 1'b1;
                8'h05:   wr_phase_s = 1'b1;
                8'h06:   wr_ctrl_s  = 1'b1;
                default: unknown_s  = 1'b1;
            endcase
        end else begin
            unknown_s = 1'b0;
        end
    end

    assign apply_s = wr_ctrl_s && data_r[1];

    // Shadow registers; live outputs only pick these up on apply or sweep expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r <= 28'd0;
            step_r  <= 28'd0;
            stop_r  <= 28'd0;
            phase_r <= 28'd0;
            dwell_r <= 32'd1;
        end else begin
            if (wr_start_s) start_r <= data_r[27:0];
            if (wr_step_s)  step_r  <= data_r[27:0];
            if (wr_stop_s)  stop_r  <= data_r[27:0];
            if (wr_phase_s) phase_r <= data_r[27:0];
            if (wr_dwell_s) dwell_r <= data_r;
        end
    end

    // A DWELL of zero behaves like one so the sweep never stalls
    assign dwell_lim_s = (dwell_r == 32'd0) ? 32'd1 : dwell_r;
    assign expire_s    = active_r && (dwell_cnt_r == (dwell_lim_s - 32'd1));
    assign sum_s       = {1'b0, fre_r} + {1'b0, step_r};
    assign over_s      = sum_s > {1'b0, stop_r};

    // Live control words and sweep engine; apply takes priority over a coincident expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fre_r       <= 28'd0;
            pha_r       <= 28'd0;
            active_r    <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            dwell_cnt_r <= 32'd0;
        end else begin
            wrap_r <= 1'b0;
            err_r  <= timeout_s || unknown_s;
            if (apply_s) begin
                fre_r       <= start_r;
                pha_r       <= phase_r;
                dwell_cnt_r <= 32'd0;
                active_r    <= data_r[0];
            end else begin
                if (wr_ctrl_s) begin
                    active_r <= data_r[0];
                end
                if (active_r) begin
                    if (expire_s) begin
                        dwell_cnt_r <= 32'd0;
                        if (over_s) begin
                            fre_r  <= start_r;
                            wrap_r <= 1'b1;
                        end else begin
                            fre_r <= sum_s[27:0];
                        end
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + 32'd1;
                    end
                end
            end
        end
    end

    assign fre_chtr     = fre_r;
    assign pha_chtr     = pha_r;
    assign sweep_active = active_r;
    assign sweep_wrap   = wrap_r;
    assign cmd_err      = err_r;

endmodule

// File: tb/tb_nco_ctrl_loader.sv
// Directed testbench for nco_ctrl_loader: frame parsing, apply latency, sweep sawtooth,
// error pulses, back-to-back throughput and reset behaviour.
module tb_nco_ctrl_loader;

    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [27:0] fre_chtr;
    logic [27:0] pha_chtr;
    logic        sweep_active;
    logic        sweep_wrap;
    logic        cmd_err;

    int n_vec = 0;
    int n_err = 0;
    int err_pulses = 0;
    int ready_low = 0;
    int base;

    nco_ctrl_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .fre_chtr     (fre_chtr),
        .pha_chtr     (pha_chtr),
        .sweep_active (sweep_active),
        .sweep_wrap   (sweep_wrap),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background monitors sampled on the inactive edge
    always @(negedge clk) begin
        if (cmd_err) err_pulses++;
        if (rst_n && !cmd_ready) ready_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 16) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [31:0] data);
        send_byte(addr);
        send_byte(data[31:24]);
        send_byte(data[23:16]);
        send_byte(data[15:8]);
        send_byte(data[7:0]);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [27:0] exp_seq [3];
        exp_seq[0] = 28'd110;
        exp_seq[1] = 28'd120;
        exp_seq[2] = 28'd100;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        #3;
        chk("rst_fre",   32'(fre_chtr), 32'd0);
        chk("rst_pha",   32'(pha_chtr), 32'd0);
        chk("rst_act",   {31'd0, sweep_active}, 32'd0);
        chk("rst_wrap",  {31'd0, sweep_wrap}, 32'd0);
        chk("rst_err",   {31'd0, cmd_err}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Static tone: shadows only, then apply
        send_frame(8'h05, 32'h0400_0000);
        send_frame(8'h01, 32'h0100_0000);
        chk("shadow_only_fre", 32'(fre_chtr), 32'd0);
        chk("shadow_only_pha", 32'(pha_chtr), 32'd0);
        send_frame(8'h06, 32'h0000_0002);
        chk("commit_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("commit_fre_old", 32'(fre_chtr), 32'd0);
        tick();
        chk("apply_fre", 32'(fre_chtr), 32'h0100_0000);
        chk("apply_pha", 32'(pha_chtr), 32'h0400_0000);
        chk("apply_act", {31'd0, sweep_active}, 32'd0);

        // Sawtooth sweep 100,110,120,100 every 4 cycles
        send_frame(8'h01, 32'd100);
        send_frame(8'h02, 32'd10);
        send_frame(8'h03, 32'd125);
        send_frame(8'h04, 32'd4);
        send_frame(8'h06, 32'h0000_0003);
        tick();
        chk("sweep_start", 32'(fre_chtr), 32'd100);
        chk("sweep_act", {31'd0, sweep_active}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            chk("sweep_hold", 32'(fre_chtr), (i == 0) ? 32'd100 : 32'(exp_seq[i-1]));
            tick();
            chk("sweep_step", 32'(fre_chtr), 32'(exp_seq[i]));
            chk("sweep_wrap", {31'd0, sweep_wrap}, (i == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("wrap_one_cycle", {31'd0, sweep_wrap}, 32'd0);

        // Unknown address: no output change, one error pulse
        send_frame(8'h06, 32'h0000_0002);
        tick();
        chk("freeze_fre", 32'(fre_chtr), 32'd100);
        base = err_pulses;
        send_frame(8'h7F, 32'hDEAD_BEEF);
        chk("unk_err_commit", {31'd0, cmd_err}, 32'd0);
        tick();
        chk("unk_err_pulse", {31'd0, cmd_err}, 32'd1);
        tick();
        chk("unk_err_clear", {31'd0, cmd_err}, 32'd0);
        chk("unk_fre", 32'(fre_chtr), 32'd100);
        chk("unk_pha", 32'(pha_chtr), 32'h0400_0000);
        chk("unk_err_count", 32'(err_pulses - base), 32'd1);
        send_frame(8'h01, 32'h0000_0200);
        send_frame(8'h06, 32'h0000_0002);
        tick();
        chk("after_unk_fre", 32'(fre_chtr), 32'h200);

        // Inter-byte timeout discards a partial frame
        base = err_pulses;
        send_byte(8'h01);
        send_byte(8'h0F);
        repeat (TIMEOUT) tick();
        send_frame(8'h01, 32'h00AB_CDEF);
        send_frame(8'h06, 32'h0000_0002);
        tick();
        chk("timeout_err_count", 32'(err_pulses - base), 32'd1);
        chk("timeout_start", 32'(fre_chtr), 32'h00AB_CDEF);

        // Back-to-back bytes: exactly one not-ready cycle per frame
        tick();
        ready_low = 0;
        send_frame(8'h01, 32'h0000_0111);
        send_frame(8'h05, 32'h0000_0222);
        send_frame(8'h06, 32'h0000_0002);
        tick();
        chk("b2b_ready_low", 32'(ready_low), 32'd3);
        chk("b2b_fre", 32'(fre_chtr), 32'h111);
        chk("b2b_pha", 32'(pha_chtr), 32'h222);

        // Reset mid-sweep and mid-frame
        send_frame(8'h01, 32'd100);
        send_frame(8'h03, 32'd1000);
        send_frame(8'h04, 32'd2);
        send_frame(8'h06, 32'h0000_0003);
        repeat (5) tick();
        chk("pre_rst_act", {31'd0, sweep_active}, 32'd1);
        send_byte(8'h05);
        send_byte(8'h00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fre", 32'(fre_chtr), 32'd0);
        chk("mid_rst_pha", 32'(pha_chtr), 32'd0);
        chk("mid_rst_act", {31'd0, sweep_active}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_act", {31'd0, sweep_active}, 32'd0);
        chk("post_rst_fre", 32'(fre_chtr), 32'd0);
        send_frame(8'h05, 32'h0000_0123);
        send_frame(8'h06, 32'h0000_0002);
        tick();
        chk("post_rst_pha", 32'(pha_chtr), 32'h123);
        chk("post_rst_fre_start0", 32'(fre_chtr), 32'd0);
        chk("post_rst_act2", {31'd0, sweep_active}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_ctrl_loader.md
# nco_ctrl_loader

Command-driven control-word generator sitting directly upstream of the NCO. It parses 5-byte register-write frames arriving from the USB3 receive path, holds shadow copies of frequency/phase/sweep settings, and drives the NCO's 28-bit `fre_chtr` and `pha_chtr` inputs. It can hold a static tone or run a linear up-sweep (sawtooth) between start and stop frequencies with programmable dwell.

## Interface
- `TIMEOUT`, 1024: maximum idle cycles between bytes of one frame before a partial frame is discarded.
- `clk` input 1: system clock, same domain as the NCO.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cmd_data` input 8: command byte stream.
- `cmd_valid` input 1: `cmd_data` valid; a byte is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_ready` output 1: loader can accept a byte.
- `fre_chtr` output 28: live frequency control word to the NCO; 2^26 = clk/4.
- `pha_chtr` output 28: live phase control word to the NCO; 2^26 = 90°.
- `sweep_active` output 1: sweep running.
- `sweep_wrap` output 1: one-cycle pulse when the sweep reloads its start value.
- `cmd_err` output 1: one-cycle pulse on an unknown address or frame timeout.

## Operation
- Frame format: byte0 is the address; bytes1-4 carry 32-bit data, MSB first. Registers use data[27:0], except DWELL, which uses all 32 bits, and CTRL, which uses bits [1:0].
- Addresses:
  - 0x01 START
  - 0x02 STEP
  - 0x03 STOP
  - 0x04 DWELL
  - 0x05 PHASE
  - 0x06 CTRL: bit0 sweep_en, bit1 apply.
- Parser states:
  - ADDR: wait for byte0, then go to DATA with byte count 0.
  - DATA: accept 4 bytes, then go to COMMIT.
  - COMMIT: one cycle, then return to ADDR.
- `cmd_ready` is decoded from the state register: high in ADDR and DATA, low in COMMIT.
- An unknown address is still consumed as a full 5-byte frame. In COMMIT it produces no register write and pulses `cmd_err`.
- Timeout: in DATA, an idle counter increments on every cycle with no byte accepted. It is cleared on each accept.
  - When the counter reaches `TIMEOUT`, the partial frame is discarded, the state returns to ADDR, and `cmd_err` pulses.
- Writes to START, STEP, STOP, DWELL and PHASE update shadows only; live outputs do not change.
- A CTRL write with apply=1 does the following:
  - `fre_chtr` ← START shadow, `pha_chtr` ← PHASE shadow, dwell counter ← 0.
  - `sweep_active` ← sweep_en.
  - If `sweep_active` was already set, the sweep restarts from START.
- A CTRL write with apply=0 only updates `sweep_active` ← sweep_en (0 freezes the current frequency; 1 resumes from it).
- Sweep, while `sweep_active`=1: the dwell counter increments each cycle. When it equals max(DWELL,1)−1, the counter clears and the following applies:
  - If `fre_chtr` + STEP (29-bit unsigned sum) > STOP: `fre_chtr` ← START and `sweep_wrap` pulses.
  - Otherwise `fre_chtr` ← `fre_chtr` + STEP.
- If START > STOP, every dwell expiry reloads START and pulses `sweep_wrap`.
- The sweep uses the shadow START/STEP/STOP/DWELL values current at each expiry.

## Timing
- Reset values:
  - `fre_chtr` = 0, `pha_chtr` = 0.
  - `sweep_active` = 0, `sweep_wrap` = 0, `cmd_err` = 0.
  - `cmd_ready` = 1 (state ADDR).
  - Shadows 0, except DWELL = 1.
  - Idle counter and dwell counter 0.
- Latency: the 5th byte is accepted at edge N; COMMIT is occupied during cycle N+1; the register write happens at edge N+1.
  - Outputs show the new value from cycle N+2.
  - `cmd_err` for an unknown address is high during cycle N+2.
- Maximum throughput is one frame per 6 cycles.
- First sweep step is the max(DWELL,1)-th edge after the apply edge. The steady step period is max(DWELL,1) cycles.
- If an apply edge coincides with a dwell expiry, the apply wins: `fre_chtr` = START, the counter clears, and there is no step or wrap.
- `fre_chtr` arithmetic wraps modulo 2^28, but the >STOP reload check prevents wrap in practice whenever STOP < 2^28.
- Reset asserted mid-frame or mid-sweep forces all reset values immediately; the next byte after release is treated as an address.

## Test plan
- Reset, then frames PHASE=0x4000000, START=0x1000000, CTRL=0x2 -> `fre_chtr`=0x1000000 and `pha_chtr`=0x4000000 two cycles after the last CTRL byte; `sweep_active`=0.
- START=100, STEP=10, STOP=125, DWELL=4, CTRL=0x3 -> `fre_chtr` goes 100, 110, 120, 100, changing every 4 cycles; `sweep_wrap` pulses on the 100 reload.
- Frame with address 0x7F and any data -> no output change; `cmd_err` pulses once; the next valid frame is parsed correctly.
- Send 2 bytes, idle `TIMEOUT` cycles, then send a full START frame -> `cmd_err` pulses once and START is written correctly.
- Hold `cmd_valid` high with back-to-back bytes -> `cmd_ready` is low exactly one cycle per frame and no byte is lost.
- Assert `rst_n` low mid-sweep and mid-frame -> all outputs zero immediately; after release the sweep stays off and the first byte is parsed as an address.
